// File: rtl/elevator_car_ctrl.sv
// Purpose: car motion and door sequencing for one elevator; floor calls are served in SCAN order.
// Latency: a call is visible on call_pending 1 clk after sampling; the car leaves IDLE on the following clk.
// Backpressure: none; call_req is a level/pulse input, and calls are held in call_pending until served.
module elevator_car_ctrl #(
  parameter int NUM_FLOORS   = 4,
  parameter int FLOOR_W      = 2,
  parameter int TRAVEL_TICKS = 96,
  parameter int DOOR_TICKS   = 192,
  parameter int TCNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_div_96,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [NUM_FLOORS-1:0] call_pending,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MOVE = 2'd1;
  localparam logic [1:0] ST_DOOR = 2'd2;

  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [TCNT_W-1:0]  TRAVEL_LAST = TCNT_W'(TRAVEL_TICKS - 1);
  localparam logic [TCNT_W-1:0]  DOOR_LAST   = TCNT_W'(DOOR_TICKS - 1);

  logic [1:0]            state, state_nxt;
  logic [TCNT_W-1:0]     timer, timer_nxt;
  logic [FLOOR_W-1:0]    floor_nxt, step_floor;
  logic                  dir_nxt;
  logic [NUM_FLOORS-1:0] pend_nxt;
  logic                  s1, s2, prev, tick;
  logic                  pend_here, pend_up, pend_dn;

  // True when any call is latched strictly above floor f.
  function automatic logic any_above(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i > int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  // True when any call is latched strictly below floor f.
  function automatic logic any_below(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i < int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  // Bring the slow divider output into this domain as data; the last two stages give edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= clk_div_96;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign tick = s2 & ~prev;

  assign pend_here  = call_pending[floor];
  assign pend_up    = any_above(call_pending, floor);
  assign pend_dn    = any_below(call_pending, floor);
  assign step_floor = dir_up ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);

  // Next-state: call latching, SCAN direction choice, travel and door timing.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    floor_nxt = floor;
    dir_nxt   = dir_up;
    pend_nxt  = call_pending | call_req;

    case (state)
      ST_IDLE: begin
        if (pend_here) begin
          pend_nxt[floor] = 1'b0;
          state_nxt       = ST_DOOR;
          timer_nxt       = '0;
        end else if (|call_pending) begin
          // Reverse only when nothing remains ahead but something waits behind.
          if (dir_up ? (!pend_up && pend_dn) : (!pend_dn && pend_up))
            dir_nxt = ~dir_up;
          if (floor == '0)       dir_nxt = 1'b1;
          if (floor == TOP_FLOOR) dir_nxt = 1'b0;
          state_nxt = ST_MOVE;
          timer_nxt = '0;
        end
      end

      ST_MOVE: begin
        if (tick) begin
          if (timer == TRAVEL_LAST) begin
            timer_nxt = '0;
            floor_nxt = step_floor;
            if (call_pending[step_floor]) begin
              pend_nxt[step_floor] = 1'b0;
              state_nxt            = ST_DOOR;
            end else if (dir_up ? any_above(call_pending, step_floor)
                                : any_below(call_pending, step_floor)) begin
              state_nxt = ST_MOVE;
            end else begin
              state_nxt = ST_IDLE;
            end
            // An end floor leaves only one way to go.
            if (step_floor == '0)       dir_nxt = 1'b1;
            if (step_floor == TOP_FLOOR) dir_nxt = 1'b0;
          end else begin
            timer_nxt = timer + TCNT_W'(1);
          end
        end
      end

      ST_DOOR: begin
        if (call_req[floor]) begin
          // A call at this floor just holds the door; it is not queued for later.
          pend_nxt[floor] = call_pending[floor];
          timer_nxt       = '0;
        end else if (tick) begin
          if (timer == DOOR_LAST) begin
            state_nxt = ST_IDLE;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + TCNT_W'(1);
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // State and registered outputs; moving/door_open are decoded from next state so they track state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      floor        <= '0;
      dir_up       <= 1'b1;
      call_pending <= '0;
      moving       <= 1'b0;
      door_open    <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      floor        <= floor_nxt;
      dir_up       <= dir_nxt;
      call_pending <= pend_nxt;
      moving       <= (state_nxt == ST_MOVE);
      door_open    <= (state_nxt == ST_DOOR);
    end
  end

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Bench for elevator_car_ctrl: directed scenarios followed by random calls, divider stalls and resets.
// Every clk, DUT outputs are compared against a behavioural car model kept in this file.
// The model works in plain integers (floor number, tick count, pending set) rather than RTL signals.
module tb_elevator_car_ctrl;
  localparam int NF = 4;
  localparam int TT = 2;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_div_96;
  logic [3:0] call_req;
  logic [3:0] call_pending;
  logic [1:0] floor;
  logic       dir_up, moving, door_open;

  always #5 clk = ~clk;

  elevator_car_ctrl #(
    .NUM_FLOORS(NF), .FLOOR_W(2), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT), .TCNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .clk_div_96(clk_div_96), .call_req(call_req),
    .call_pending(call_pending), .floor(floor), .dir_up(dir_up),
    .moving(moving), .door_open(door_open)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_MOVE, M_DOOR} mode_e;
  mode_e    m_mode;
  int       m_floor, m_timer;
  bit       m_up;
  bit [3:0] m_pend;
  bit       h0, h1, h2;   // last three sampled divider levels, newest first
  int       divcnt;
  bit       div_run;

  function automatic bit pend_in(int lo, int hi);
    for (int j = lo; j <= hi; j++)
      if (j >= 0 && j < NF && m_pend[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit       tk, ab, be, ahead, behind;
    bit [3:0] np;
    int       nf;
    if (rst) begin
      m_mode = M_IDLE; m_floor = 0; m_timer = 0; m_up = 1'b1; m_pend = '0;
      h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
      return;
    end
    // A rising divider level seen two and three samples ago is one tick.
    tk = h1 && !h2;
    h2 = h1; h1 = h0; h0 = clk_div_96;
    np = m_pend | call_req;
    case (m_mode)
      M_IDLE: begin
        if (m_pend[m_floor]) begin
          np[m_floor] = 1'b0; m_mode = M_DOOR; m_timer = 0;
        end else if (m_pend != 0) begin
          ab = pend_in(m_floor + 1, NF - 1);
          be = pend_in(0, m_floor - 1);
          ahead  = m_up ? ab : be;
          behind = m_up ? be : ab;
          if (!ahead && behind) m_up = !m_up;
          if (m_floor == 0)      m_up = 1'b1;
          if (m_floor == NF - 1) m_up = 1'b0;
          m_mode = M_MOVE; m_timer = 0;
        end
      end
      M_MOVE: begin
        if (tk) begin
          if (m_timer == TT - 1) begin
            nf = m_up ? m_floor + 1 : m_floor - 1;
            m_timer = 0;
            if (m_pend[nf]) begin
              np[nf] = 1'b0; m_mode = M_DOOR;
            end else if (!(m_up ? pend_in(nf + 1, NF - 1) : pend_in(0, nf - 1))) begin
              m_mode = M_IDLE;
            end
            m_floor = nf;
            if (nf == 0)      m_up = 1'b1;
            if (nf == NF - 1) m_up = 1'b0;
          end else begin
            m_timer++;
          end
        end
      end
      M_DOOR: begin
        if (call_req[m_floor]) begin
          np[m_floor] = m_pend[m_floor];
          m_timer = 0;
        end else if (tk) begin
          if (m_timer == DT - 1) begin
            m_mode = M_IDLE; m_timer = 0;
          end else begin
            m_timer++;
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
    m_pend = np;
  endtask

  // One clk: model follows the edge, outputs compared on the falling edge, then divider advances.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("floor",        32'(floor),        32'(m_floor));
    chk("dir_up",       32'(dir_up),       32'(m_up));
    chk("moving",       32'(moving),       32'(m_mode == M_MOVE));
    chk("door_open",    32'(door_open),    32'(m_mode == M_DOOR));
    chk("call_pending", 32'(call_pending), 32'(m_pend));
    chk("excl",         32'(moving & door_open), 32'(0));
    if (div_run) divcnt++;
    clk_div_96 = ((divcnt / 4) % 2) == 1;
  endtask

  task automatic pulse(input logic [3:0] v);
    call_req = v;
    cycle();
    call_req = '0;
  endtask

  task automatic wait_door(input string tag, input int budget);
    int n = 0;
    while (!door_open && n < budget) begin cycle(); n++; end
    chk(tag, 32'(door_open), 32'(1));
  endtask

  task automatic wait_move(input string tag, input int budget);
    int n = 0;
    while (!moving && n < budget) begin cycle(); n++; end
    chk(tag, 32'(moving), 32'(1));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((moving || door_open) && n < budget) begin cycle(); n++; end
    chk(tag, 32'(moving | door_open), 32'(0));
  endtask

  initial begin
    rst = 1'b1; call_req = '0; clk_div_96 = 1'b0; divcnt = 0; div_run = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_floor", 32'(floor), 32'(0));
    chk("rst_dir",   32'(dir_up), 32'(1));
    chk("rst_pend",  32'(call_pending), 32'(0));

    // Call at the current floor: latched, then door opens next clk.
    pulse(4'b0001);
    chk("s3_pend", 32'(call_pending), 32'(4'b0001));
    cycle();
    chk("s3_door", 32'(door_open), 32'(1));
    chk("s3_clr",  32'(call_pending), 32'(0));
    wait_idle("s3_close", 100);

    // Travel from floor 0 to floor 3.
    pulse(4'b1000);
    wait_move("s4_move", 10);
    wait_door("s4_door", 200);
    chk("s4_floor", 32'(floor), 32'(3));
    chk("s4_pend3", 32'(call_pending[3]), 32'(0));
    wait_idle("s4_close", 100);

    // SCAN: go to floor 1, start up toward 3, then add a call at 0.
    pulse(4'b0010);
    wait_door("s5_at1", 200);
    chk("s5_floor1", 32'(floor), 32'(1));
    wait_idle("s5_idle1", 100);
    pulse(4'b1000);
    wait_move("s5_up", 10);
    pulse(4'b0001);
    wait_door("s5_door3", 200);
    chk("s5_first", 32'(floor), 32'(3));
    wait_move("s5_down", 100);
    chk("s5_dir", 32'(dir_up), 32'(0));
    wait_door("s5_door0", 200);
    chk("s5_second", 32'(floor), 32'(0));
    wait_idle("s5_idle0", 100);

    // Door hold at floor 2.
    pulse(4'b0100);
    wait_door("s6_door", 200);
    chk("s6_floor", 32'(floor), 32'(2));
    repeat (10) cycle();
    pulse(4'b0100);
    chk("s6_open",  32'(door_open), 32'(1));
    chk("s6_pend2", 32'(call_pending[2]), 32'(0));
    repeat (16) cycle();
    chk("s6_held", 32'(door_open), 32'(1));
    wait_idle("s6_close", 100);

    // Reset in the middle of a move.
    pulse(4'b0001);
    wait_move("s1_move", 10);
    repeat (3) cycle();
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    chk("s1_floor",  32'(floor), 32'(0));
    chk("s1_dir",    32'(dir_up), 32'(1));
    chk("s1_moving", 32'(moving), 32'(0));
    chk("s1_door",   32'(door_open), 32'(0));
    chk("s1_pend",   32'(call_pending), 32'(0));

    // Random calls, divider stalls and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) div_run = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) call_req = 4'($urandom_range(0, 15));
      else                           call_req = '0;
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0; call_req = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
